// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle instruction controller.
package multicycle_controller_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned PC_SRC_W = 2;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_e;

  // Opcode class prefixes, matched against the top bits of the opcode
  localparam logic [1:0] CLS_REG  = 2'b00;
  localparam logic [1:0] CLS_IMM  = 2'b01;
  localparam logic [2:0] CLS_MEM  = 3'b100;
  localparam logic [2:0] CLS_CJMP = 3'b101;
  localparam logic [3:0] CLS_JMP  = 4'b1100;

  // Memory subfunction in opcode[2:1]
  localparam logic [1:0] FN_STM = 2'b00;
  localparam logic [1:0] FN_LDM = 2'b01;

  localparam logic [PC_SRC_W-1:0] PC_INC   = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_OFF   = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_CONST = 2'd2;

  typedef enum logic [2:0] {
    OC_REG     = 3'd0,
    OC_IMM     = 3'd1,
    OC_MEM     = 3'd2,
    OC_CJMP    = 3'd3,
    OC_JMP     = 3'd4,
    OC_ILLEGAL = 3'd5
  } op_class_e;

  typedef struct packed {
    op_class_e             cls;
    logic                  is_ldm;
    logic                  is_jnz;
    logic [ALU_OP_W-1:0]   alu_fn;
  } op_decode_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode into instruction class and subfunction.
module opcode_classifier
  import multicycle_controller_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_decode_t          dec
);

  always_comb begin
    dec        = '0;
    dec.cls    = OC_ILLEGAL;
    dec.alu_fn = opcode[ALU_OP_W-1:0];
    if (opcode[5:4] == CLS_REG) begin
      dec.cls = OC_REG;
    end else if (opcode[5:4] == CLS_IMM) begin
      dec.cls = OC_IMM;
    end else if (opcode[5:3] == CLS_MEM) begin
      // Only STM and LDM are defined; other memory subfunctions stay illegal
      if (opcode[2:1] == FN_STM) begin
        dec.cls = OC_MEM;
      end else if (opcode[2:1] == FN_LDM) begin
        dec.cls    = OC_MEM;
        dec.is_ldm = 1'b1;
      end
    end else if (opcode[5:3] == CLS_CJMP) begin
      dec.cls    = OC_CJMP;
      dec.is_jnz = opcode[2];
    end else if (opcode[5:2] == CLS_JMP) begin
      dec.cls = OC_JMP;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FSM sequencing fetch, decode, execute, memory and writeback.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_addr_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_load,
  output logic                pc_load,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_const,
  output logic                rf_write_en,
  output logic                rf_in_sel,
  output logic                busy,
  output logic                illegal
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] cls_op;
  op_decode_t          dec;

  // DECODE acts on the live IR opcode; later states use the latched copy
  assign cls_op = (state_q == DECODE) ? opcode : op_q;

  opcode_classifier u_classifier (
    .opcode (cls_op),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  // Next-state and output decode; everything is forced low while in reset
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_addr_sel  = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_load       = 1'b0;
    pc_load       = 1'b0;
    pc_src        = PC_INC;
    alu_op        = '0;
    alu_src_const = 1'b0;
    rf_write_en   = 1'b0;
    rf_in_sel     = 1'b0;
    busy          = 1'b0;
    illegal       = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          busy = 1'b1;
          case (dec.cls)
            OC_REG, OC_IMM, OC_MEM: state_d = EXECUTE;
            OC_JMP: begin
              pc_load = 1'b1;
              pc_src  = PC_CONST;
              state_d = FETCH;
            end
            OC_CJMP: begin
              // JZ taken on zero=1, JNZ taken on zero=0
              pc_load = 1'b1;
              pc_src  = (dec.is_jnz ^ zero) ? PC_OFF : PC_INC;
              state_d = FETCH;
            end
            default: begin
              illegal = 1'b1;
              pc_load = 1'b1;
              pc_src  = PC_INC;
              state_d = FETCH;
            end
          endcase
        end
        EXECUTE: begin
          busy          = 1'b1;
          alu_op        = dec.alu_fn;
          alu_src_const = (dec.cls != OC_REG);
          state_d       = (dec.cls == OC_MEM) ? MEMORY : WRITEBACK;
        end
        MEMORY: begin
          busy          = 1'b1;
          mem_req       = 1'b1;
          mem_addr_sel  = 1'b1;
          alu_src_const = 1'b1;
          mem_read      = dec.is_ldm;
          mem_write     = ~dec.is_ldm;
          if (mem_ready) begin
            if (dec.is_ldm) begin
              state_d = WRITEBACK;
            end else begin
              pc_load = 1'b1;
              pc_src  = PC_INC;
              state_d = FETCH;
            end
          end
        end
        WRITEBACK: begin
          busy        = 1'b1;
          rf_write_en = 1'b1;
          rf_in_sel   = dec.is_ldm;
          pc_load     = 1'b1;
          pc_src      = PC_INC;
          state_d     = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
